// File: rtl/smol_mem_pkg.sv
// Shared widths and state/owner encodings for the memory-port arbiter.
package smol_mem_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic {OWN_IF, OWN_D} owner_t;
  typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// counting out the fixed read latency and returning data to the owner.
module mem_arbiter
  import smol_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t        state, state_nxt;
  owner_t            owner;
  logic              we_q;
  logic [2:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              d_win;

  assign d_win = d_req && !(if_req && starve_cnt == STARVE_LIM);

  // Outputs are forced low while reset is held so an abandoned access
  // cannot leak an rvalid in the reset cycle itself.
  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = sync_rst ? '0 : addr_q;
    mem_wdata = sync_rst ? '0 : wdata_q;
    if (!sync_rst) begin
      case (state)
        ARB_IDLE: begin
          if (d_win) begin
            d_gnt     = 1'b1;
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            state_nxt = ARB_WAIT;
          end else if (if_req) begin
            if_gnt    = 1'b1;
            mem_en    = 1'b1;
            mem_addr  = if_addr;
            state_nxt = ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (lat_cnt == 3'd1) begin
            state_nxt = ARB_IDLE;
            if (owner == OWN_D) begin
              d_rvalid = 1'b1;
              d_rdata  = we_q ? '0 : mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      we_q       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (mem_en) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        lat_cnt <= LAT_INIT;
        owner   <= d_gnt ? OWN_D : OWN_IF;
        we_q    <= mem_we;
        if (if_gnt || !if_req)
          starve_cnt <= '0;
        else if (starve_cnt != STARVE_LIM)
          starve_cnt <= starve_cnt + 4'd1;
      end else if (state == ARB_WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1/STARVE_MAX=2,
// one at MEM_LAT=3, each with a behavioural memory model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sync_rst;

  logic       if_req_a, if_gnt_a, if_rvalid_a;
  logic [7:0] if_addr_a, if_rdata_a;
  logic       d_req_a, d_we_a, d_gnt_a, d_rvalid_a;
  logic [7:0] d_addr_a, d_wdata_a, d_rdata_a;
  logic       mem_en_a, mem_we_a;
  logic [7:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

  logic       if_req_b, if_gnt_b, if_rvalid_b;
  logic [7:0] if_addr_b, if_rdata_b;
  logic       d_req_b, d_we_b, d_gnt_b, d_rvalid_b;
  logic [7:0] d_addr_b, d_wdata_b, d_rdata_b;
  logic       mem_en_b, mem_we_b;
  logic [7:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dut_a (
    .clk(clk), .sync_rst(sync_rst),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
    .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .sync_rst(sync_rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
    .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Memory contents after reset are addr ^ 8'hB5, so expected bytes are easy to derive.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] pipe_a;
  logic [7:0] pipe_b [3];

  always @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 8'(i) ^ 8'hB5;
      pipe_a <= '0;
    end else begin
      if (mem_en_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      pipe_a <= mem_en_a ? mem_a[mem_addr_a] : 8'h00;
    end
  end

  always @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= 8'(i) ^ 8'hB5;
      for (int i = 0; i < 3; i++) pipe_b[i] <= '0;
    end else begin
      if (mem_en_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
      pipe_b[0] <= mem_en_b ? mem_b[mem_addr_b] : 8'h00;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end

  assign mem_rdata_a = pipe_a;
  assign mem_rdata_b = pipe_b[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [63:0] outs_a();
    return {28'h0, if_gnt_a, if_rvalid_a, if_rdata_a, d_gnt_a, d_rvalid_a, d_rdata_a,
            mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a};
  endfunction

  logic exp_d [6]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0] exp_sc [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};

  initial begin
    sync_rst = 1'b1;
    if_req_a = 0; if_addr_a = 0; d_req_a = 0; d_we_a = 0; d_addr_a = 0; d_wdata_a = 0;
    if_req_b = 0; if_addr_b = 0; d_req_b = 0; d_we_b = 0; d_addr_b = 0; d_wdata_b = 0;
    tick(); tick();
    sample();
    check("reset_outputs", outs_a(), 64'h0);
    check("reset_starve", 64'(dut_a.starve_cnt), 64'h0);
    tick();
    sync_rst = 1'b0;

    // Fetch only, back-to-back at MEM_LAT=1
    if_req_a = 1; if_addr_a = 8'h10;
    sample();
    check("if_gnt_t0", {if_gnt_a, d_gnt_a, mem_en_a, mem_we_a}, 4'b1010);
    check("if_addr_t0", mem_addr_a, 8'h10);
    tick();
    sample();
    check("if_rvalid_t1", {if_rvalid_a, if_gnt_a, mem_en_a}, 3'b100);
    check("if_rdata_t1", if_rdata_a, 8'hA5);
    tick();
    sample();
    check("if_gnt_t2", if_gnt_a, 1'b1);
    tick();
    if_req_a = 0;
    sample();
    check("if_rvalid_t3", if_rvalid_a, 1'b1);
    tick();

    // Simultaneous requests: data first, fetch on next slot
    if_req_a = 1; if_addr_a = 8'h20; d_req_a = 1; d_we_a = 0; d_addr_a = 8'h80;
    sample();
    check("sim_grant1", {d_gnt_a, if_gnt_a}, 2'b10);
    check("sim_addr1", mem_addr_a, 8'h80);
    tick();
    d_req_a = 0;
    sample();
    check("sim_drvalid", {d_rvalid_a, if_rvalid_a, if_gnt_a}, 3'b100);
    check("sim_drdata", d_rdata_a, 8'h35);
    tick();
    sample();
    check("sim_grant2", {d_gnt_a, if_gnt_a}, 2'b01);
    check("sim_addr2", mem_addr_a, 8'h20);
    tick();
    if_req_a = 0;
    sample();
    check("sim_irvalid", {if_rvalid_a, d_rvalid_a}, 2'b10);
    check("sim_irdata", if_rdata_a, 8'h95);
    tick();

    // Starvation at STARVE_MAX=2: D, D, IF, D, D, IF
    if_req_a = 1; d_req_a = 1;
    for (int s = 0; s < 6; s++) begin
      sample();
      check($sformatf("starve_gnt%0d", s), {d_gnt_a, if_gnt_a}, {exp_d[s], ~exp_d[s]});
      tick();
      if (s == 5) begin
        if_req_a = 0; d_req_a = 0;
      end
      sample();
      check($sformatf("starve_cnt%0d", s), 64'(dut_a.starve_cnt), 64'(exp_sc[s]));
      check($sformatf("starve_nogrant%0d", s), {d_gnt_a, if_gnt_a}, 2'b00);
      tick();
    end

    // Data write to 8'hFF, then read it back
    d_req_a = 1; d_we_a = 1; d_addr_a = 8'hFF; d_wdata_a = 8'h3C;
    sample();
    check("wr_gnt", {d_gnt_a, mem_en_a, mem_we_a}, 3'b111);
    check("wr_addr", mem_addr_a, 8'hFF);
    check("wr_wdata", mem_wdata_a, 8'h3C);
    tick();
    d_req_a = 0; d_we_a = 0; d_wdata_a = 8'h00;
    sample();
    check("wr_ack", d_rvalid_a, 1'b1);
    check("wr_ack_rdata", d_rdata_a, 8'h00);
    tick();
    sample();
    check("idle_hold", {mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a}, {2'b00, 8'hFF, 8'h3C});
    tick();
    d_req_a = 1;
    sample();
    check("rd_ff_gnt", {d_gnt_a, mem_we_a}, 2'b10);
    tick();
    d_req_a = 0;
    sample();
    check("rd_ff_data", {d_rvalid_a, d_rdata_a}, {1'b1, 8'h3C});
    tick();

    // Latency sweep on the MEM_LAT=3 instance
    if_req_b = 1; if_addr_b = 8'h42;
    sample();
    check("lat3_gnt", if_gnt_b, 1'b1);
    tick();
    if_req_b = 0; d_req_b = 1; d_addr_b = 8'h43;
    for (int w = 0; w < 2; w++) begin
      sample();
      check($sformatf("lat3_wait%0d", w), {if_gnt_b, d_gnt_b, if_rvalid_b, d_rvalid_b, mem_en_b}, 5'b0);
      tick();
    end
    sample();
    check("lat3_rvalid", {if_rvalid_b, d_gnt_b}, 2'b10);
    check("lat3_rdata", if_rdata_b, 8'hF7);
    tick();
    sample();
    check("lat3_next_gnt", d_gnt_b, 1'b1);
    tick();
    d_req_b = 0;
    tick(); tick();
    sample();
    check("lat3_d_rdata", {d_rvalid_b, d_rdata_b}, {1'b1, 8'hF6});
    tick();

    // Reset in the first WAIT cycle after d_gnt
    d_req_a = 1; d_we_a = 0; d_addr_a = 8'h05;
    sample();
    check("rst_pre_gnt", d_gnt_a, 1'b1);
    tick();
    sync_rst = 1'b1;
    sample();
    check("rst_no_rvalid", {d_rvalid_a, if_rvalid_a}, 2'b00);
    tick();
    sample();
    check("rst_outputs", outs_a(), 64'h0);
    tick();
    sync_rst = 1'b0;
    sample();
    check("rst_regrant", {d_gnt_a, mem_addr_a}, {1'b1, 8'h05});
    tick();
    d_req_a = 0;
    sample();
    check("rst_regrant_data", {d_rvalid_a, d_rdata_a}, {1'b1, 8'hB0});
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Mutual exclusion of grants, checked on every falling edge.
  always @(negedge clk) begin
    if (d_gnt_a && if_gnt_a) begin
      n_errors++;
      $display("FAIL dual_gnt_a: got both grants high expected at most one");
    end
    if (d_gnt_b && if_gnt_b) begin
      n_errors++;
      $display("FAIL dual_gnt_b: got both grants high expected at most one");
    end
  end

endmodule
